trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_pkg.sv | 31 +++
 rtl/trace_ram.sv | 27 ++
 rtl/trace_buffer.sv | 186 ++++++++++++++++++
 tb/tb_trace_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and field widths for the instruction-side trace buffer.
// Entry width depends on whether the dmem probe is built (TRACE_DMEM_EN).
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_RF   = 2'b01,
    KIND_DM   = 2'b10,
    KIND_BOTH = 2'b11
  } kind_e;

  localparam int KIND_W = 2;
  localparam int REG_W  = 5;

  function automatic int entry_w(
    input int cyc_w,
    input int data_w,
    input int addr_w,
    input bit dm_en
  );
    return cyc_w + KIND_W + REG_W + data_w
         + (dm_en ? addr_w + data_w : 0);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: synchronous write, registered read.
// Contents are never reset; validity is tracked by the controller.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trace_buffer.sv
// Regfile/dmem write trace buffer with stop or wrap capture and readout.
// Define TRACE_DMEM_EN to also capture the dmem write probe.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CYC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rf_we,
  input  logic [REG_W-1:0]         rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     dm_we,
  input  logic [ADDR_W-1:0]        dm_addr,
  input  logic [DATA_W-1:0]        dm_wdata,
  input  logic                     arm,
  input  logic                     wrap_mode,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [KIND_W-1:0]        rd_kind,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_rfdata,
  output logic [ADDR_W-1:0]        rd_dmaddr,
  output logic [DATA_W-1:0]        rd_dmdata,
  output logic [CYC_W-1:0]         cycle_num,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef TRACE_DMEM_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif
  localparam int ENT_W  = entry_w(CYC_W, DATA_W, ADDR_W, DM_EN);
  localparam int RF_LSB = DM_EN ? ADDR_W + DATA_W : 0;
  localparam int RG_LSB = RF_LSB + DATA_W;
  localparam int KD_LSB = RG_LSB + REG_W;
  localparam int CY_LSB = KD_LSB + KIND_W;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wrap_q, wrap_d;
  logic              rd_valid_q, rd_valid_d;

  logic              rf_ev, dm_ev, ev;
  logic              clr, rd_fire, stop_full;
  kind_e             kind;
  logic [ENT_W-1:0]  wdata, rdata;

  assign rf_ev = rf_we && (rf_waddr != '0);

`ifdef TRACE_DMEM_EN
  assign dm_ev = dm_we;
  assign wdata = {cyc_q, kind, rf_waddr, rf_wdata, dm_addr, dm_wdata};
`else
  logic unused_dm;
  assign unused_dm = ^{dm_we, dm_addr, dm_wdata};
  assign dm_ev = 1'b0;
  assign wdata = {cyc_q, kind, rf_waddr, rf_wdata};
`endif

  assign kind      = kind_e'({dm_ev, rf_ev});
  assign ev        = (state_q == ST_CAPTURE) && (rf_ev || dm_ev);
  assign clr       = arm && (state_q != ST_CAPTURE);
  assign rd_fire   = (state_q == ST_DONE) && rd_req
                  && !arm && (cnt_q != '0);
  assign stop_full = ev && !wrap_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      wrap_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      wrap_q     <= wrap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arm) state_d = ST_CAPTURE;
      ST_CAPTURE: if (arm || stop_full) state_d = ST_DONE;
      ST_DONE: begin
        if (arm) state_d = ST_CAPTURE;
        else if (rd_fire && cnt_q == CNT_ONE) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d      = cyc_q + CYC_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    wrap_d     = wrap_q;
    rd_valid_d = rd_fire;
    unique case (1'b1)
      clr: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        wrap_d   = wrap_mode;
      end
      ev: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        // A full buffer only stays in capture in wrap mode
        if (cnt_q == CNT_FULL) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          ovf_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      rd_fire: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        cnt_d    = cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clock (clock),
    .we    (ev),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .re    (rd_fire),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_cycle  = rd_valid_q ? rdata[CY_LSB +: CYC_W]  : '0;
  assign rd_kind   = rd_valid_q ? rdata[KD_LSB +: KIND_W] : '0;
  assign rd_reg    = rd_valid_q ? rdata[RG_LSB +: REG_W]  : '0;
  assign rd_rfdata = rd_valid_q ? rdata[RF_LSB +: DATA_W] : '0;
`ifdef TRACE_DMEM_EN
  assign rd_dmaddr = rd_valid_q ? rdata[DATA_W +: ADDR_W] : '0;
  assign rd_dmdata = rd_valid_q ? rdata[0 +: DATA_W]      : '0;
`else
  assign rd_dmaddr = '0;
  assign rd_dmdata = '0;
`endif

  assign cycle_num = cyc_q;
  assign state     = state_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer with a readout scoreboard.
module tb_trace_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int CYC_W  = 32;

  logic              clock, reset_n;
  logic              rf_we, dm_we, arm, wrap_mode, rd_req;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata, dm_wdata;
  logic [ADDR_W-1:0] dm_addr;
  logic              rd_valid, overflow;
  logic [CYC_W-1:0]  rd_cycle, cycle_num;
  logic [1:0]        rd_kind, state;
  logic [4:0]        rd_reg;
  logic [DATA_W-1:0] rd_rfdata, rd_dmdata;
  logic [ADDR_W-1:0] rd_dmaddr;
  logic [2:0]        count;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [1:0]        kind;
    logic [4:0]        rg;
    logic [DATA_W-1:0] rfd;
    logic [ADDR_W-1:0] dma;
    logic [DATA_W-1:0] dmd;
  } ent_t;

  ent_t             exp_q[$];
  int               n_chk  = 0;
  int               n_fail = 0;
  int               n_pulse = 0;
  logic [CYC_W-1:0] tb_cyc;
  logic [CYC_W-1:0] cy [1:6];

  trace_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .CYC_W(CYC_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .arm(arm), .wrap_mode(wrap_mode), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_kind(rd_kind),
    .rd_reg(rd_reg), .rd_rfdata(rd_rfdata),
    .rd_dmaddr(rd_dmaddr), .rd_dmdata(rd_dmdata),
    .cycle_num(cycle_num), .state(state),
    .count(count), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference cycle counter: value seen during the current cycle
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_cyc <= '0;
    else          tb_cyc <= tb_cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic ent_t mk(input logic [CYC_W-1:0] c,
                              input logic [1:0] k,
                              input logic [4:0] r,
                              input logic [DATA_W-1:0] d,
                              input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] m);
    ent_t e;
    e.cyc = c; e.kind = k; e.rg = r;
    e.rfd = d; e.dma = a; e.dmd = m;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && rd_valid) begin
      ent_t got, e;
      n_pulse++;
      got = mk(rd_cycle, rd_kind, rd_reg, rd_rfdata,
               rd_dmaddr, rd_dmdata);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h, expected no entry", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL rd_entry: got %h, expected %h", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm_pulse(input logic w);
    arm = 1'b1; wrap_mode = w;
    tick();
    arm = 1'b0; wrap_mode = 1'b0;
  endtask

  task automatic rf_wr(input logic [4:0] r,
                       input logic [DATA_W-1:0] d,
                       output logic [CYC_W-1:0] c);
    rf_we = 1'b1; rf_waddr = r; rf_wdata = d;
    c = tb_cyc;
    tick();
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
  endtask

  task automatic rd_n(input int n);
    rd_req = 1'b1;
    repeat (n) tick();
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [CYC_W-1:0] c;
    reset_n = 1'b1;
    rf_we = 0; rf_waddr = 0; rf_wdata = 0;
    dm_we = 0; dm_addr = 0; dm_wdata = 0;
    arm = 0; wrap_mode = 0; rd_req = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_cycle", cycle_num, 0);
    check("rst_rd_cycle", rd_cycle, 0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("cycle_after3", cycle_num, 3);

    // Stop mode: six writes, first four kept
    arm_pulse(1'b0);
    check("stop_state_cap", state, 1);
    for (int i = 1; i <= 6; i++) begin
      rf_wr(5'(i), 32'h100 + i, c);
      cy[i] = c;
      if (i == 4) check("stop_done_at4", state, 2);
    end
    check("stop_count", count, 4);
    check("stop_state", state, 2);
    check("stop_ovf", overflow, 0);
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(mk(cy[i], 2'b01, 5'(i), 32'h100 + i, '0, '0));
    rd_n(4);
    check("stop_rd_state", state, 0);
    check("stop_rd_count", count, 0);

    // Wrap mode: six writes, manual stop, newest four kept
    arm_pulse(1'b1);
    for (int i = 1; i <= 6; i++) begin
      rf_wr(5'(i), 32'h200 + i, c);
      cy[i] = c;
    end
    check("wrap_count", count, 4);
    check("wrap_ovf", overflow, 1);
    check("wrap_state_cap", state, 1);
    arm_pulse(1'b0);
    check("wrap_state_done", state, 2);
    for (int i = 3; i <= 6; i++)
      exp_q.push_back(mk(cy[i], 2'b01, 5'(i), 32'h200 + i, '0, '0));
    rd_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) check("wrap_state_rd3", state, 2);
    end
    rd_req = 1'b0;
    check("wrap_state_idle", state, 0);
    tick();
    check("wrap_ovf_sticky", overflow, 1);

    // Simultaneous regfile and dmem write
    arm_pulse(1'b0);
    check("arm_clears_ovf", overflow, 0);
    rf_we = 1; rf_waddr = 5'd7; rf_wdata = 32'hDEAD;
    dm_we = 1; dm_addr = 12'h010; dm_wdata = 32'hBEEF;
    c = tb_cyc;
    tick();
    rf_we = 0; rf_waddr = 0; rf_wdata = 0;
    dm_we = 0; dm_addr = 0; dm_wdata = 0;
    check("both_count", count, 1);
    arm_pulse(1'b0);
`ifdef TRACE_DMEM_EN
    exp_q.push_back(mk(c, 2'b11, 5'd7, 32'hDEAD, 12'h010, 32'hBEEF));
`else
    exp_q.push_back(mk(c, 2'b01, 5'd7, 32'hDEAD, '0, '0));
`endif
    rd_n(1);

    // Write to r0 is not an event
    arm_pulse(1'b0);
    rf_wr(5'd0, 32'h1234, c);
    check("r0_count", count, 0);
    rf_wr(5'd5, 32'h55, c);
    check("r5_count", count, 1);
    arm_pulse(1'b0);
    exp_q.push_back(mk(c, 2'b01, 5'd5, 32'h55, '0, '0));
    rd_n(1);

    // Reset mid-capture
    arm_pulse(1'b0);
    for (int i = 1; i <= 3; i++) rf_wr(5'(i), 32'h300 + i, c);
    check("mid_count3", count, 3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_count", count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_cycle", cycle_num, 1);
    arm_pulse(1'b0);
    rf_wr(5'd9, 32'h99, c);
    check("mid_rearm_count", count, 1);
    arm_pulse(1'b0);
    exp_q.push_back(mk(c, 2'b01, 5'd9, 32'h99, '0, '0));
    rd_n(1);

    // Readout gating and back-to-back reads
    rd_req = 1'b1;
    tick();
    check("idle_rd_valid", rd_valid, 0);
    rd_req = 1'b0;
    arm_pulse(1'b0);
    rf_wr(5'd10, 32'hA0, cy[1]);
    rf_wr(5'd11, 32'hB0, cy[2]);
    rd_req = 1'b1;
    tick();
    check("cap_rd_valid", rd_valid, 0);
    check("cap_rd_count", count, 2);
    rd_req = 1'b0;
    arm_pulse(1'b0);
    exp_q.push_back(mk(cy[1], 2'b01, 5'd10, 32'hA0, '0, '0));
    exp_q.push_back(mk(cy[2], 2'b01, 5'd11, 32'hB0, '0, '0));
    n_pulse = 0;
    rd_n(3);
    tick();
    check("b2b_pulses", n_pulse, 2);
    check("b2b_state", state, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
